// File: rtl/agc_seq_fsm.sv
// agc_seq_fsm: instruction fetch/decode FSM with INDEX/EXTEND qualification and TP/MCT sequencing.
module agc_seq_fsm #(
    parameter int WORD_W     = 15,
    parameter int TP_PER_MCT = 12,
    parameter int TC_MCT     = 1,
    parameter int STD_MCT    = 2,
    parameter int MP_MCT     = 3,
    parameter int DV_MCT     = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          instr_valid,
    input  logic [WORD_W-1:0]             instr_in,
    input  logic [WORD_W-1:0]             index_val,
    output logic                          fetch_req,
    output logic [4:0]                    state,
    output logic [$clog2(TP_PER_MCT)-1:0] tp,
    output logic [2:0]                    mct,
    output logic [WORD_W-1:0]             eff_instr,
    output logic                          op_start,
    output logic                          op_done,
    output logic                          extracode,
    output logic                          index_pending,
    output logic                          illegal
);
    localparam int TP_W = $clog2(TP_PER_MCT);

    typedef enum logic [4:0] {
        S_LOAD = 5'd0, S_TC = 5'd1, S_CCS = 5'd2, S_INDEX = 5'd3, S_XCH = 5'd4,
        S_CS = 5'd5, S_TS = 5'd6, S_AD = 5'd7, S_MASK = 5'd8, S_SU = 5'd9,
        S_MP = 5'd10, S_DV = 5'd11, S_EXTEND = 5'd12
    } state_t;

    state_t            state_q, state_d, dec;
    logic [TP_W-1:0]   tp_q, tp_d;
    logic [2:0]        mct_q, mct_d, n_mct;
    logic [WORD_W-1:0] eff_q, eff_d, ireg_q, ireg_d, w;
    logic              ext_q, ext_d, pend_q, pend_d;
    logic              start_q, start_d, ill_q, ill_d;
    logic [2:0]        op;
    logic [1:0]        qc;
    logic              tp_wrap, last;

    always_comb begin
        w  = instr_in + (pend_q ? ireg_q : '0);
        op = w[14:12];
        qc = w[11:10];
        // The bare word 6 is EXTEND in either mode; everything else splits on extracode.
        dec = (w == WORD_W'(6)) ? S_EXTEND :
              ext_q ? ((op == 3'd1 && qc == 2'd0) ? S_DV :
                       (op == 3'd5 && qc == 2'd0) ? S_INDEX :
                       (op == 3'd6) ? S_SU :
                       (op == 3'd7) ? S_MP : S_LOAD) :
                      ((op == 3'd0) ? S_TC :
                       (op == 3'd1) ? S_CCS :
                       (op == 3'd4) ? S_CS :
                       (op == 3'd5 && qc == 2'd0) ? S_INDEX :
                       (op == 3'd5 && qc == 2'd2) ? S_TS :
                       (op == 3'd5 && qc == 2'd3) ? S_XCH :
                       (op == 3'd6) ? S_AD :
                       (op == 3'd7) ? S_MASK : S_LOAD);
        n_mct = (state_q == S_TC || state_q == S_INDEX || state_q == S_EXTEND) ? 3'(TC_MCT) :
                (state_q == S_MP) ? 3'(MP_MCT) :
                (state_q == S_DV) ? 3'(DV_MCT) : 3'(STD_MCT);
        tp_wrap = tp_q == TP_W'(TP_PER_MCT - 1);
        last    = state_q != S_LOAD && tp_wrap && mct_q == n_mct - 3'd1;
    end

    always_comb begin
        state_d = state_q;
        tp_d    = tp_q;
        mct_d   = mct_q;
        eff_d   = eff_q;
        ireg_d  = ireg_q;
        ext_d   = ext_q;
        pend_d  = pend_q;
        start_d = 1'b0;
        ill_d   = 1'b0;
        if (state_q == S_LOAD) begin
            if (instr_valid) begin
                eff_d   = w;
                pend_d  = 1'b0;
                state_d = dec;
                tp_d    = '0;
                mct_d   = '0;
                start_d = dec != S_LOAD;
                ill_d   = dec == S_LOAD;
                ext_d   = (dec == S_LOAD) ? 1'b0 : ext_q;
            end
        end else begin
            tp_d  = tp_wrap ? '0 : tp_q + 1'b1;
            mct_d = tp_wrap ? mct_q + 3'd1 : mct_q;
            if (last) begin
                state_d = S_LOAD;
                mct_d   = '0;
                ext_d   = (state_q == S_EXTEND) ? 1'b1 : (state_q == S_INDEX) ? ext_q : 1'b0;
                pend_d  = (state_q == S_INDEX) ? 1'b1 : pend_q;
                ireg_d  = (state_q == S_INDEX) ? index_val : ireg_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            tp_q    <= '0;
            mct_q   <= '0;
            eff_q   <= '0;
            ireg_q  <= '0;
            ext_q   <= 1'b0;
            pend_q  <= 1'b0;
            start_q <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tp_q    <= tp_d;
            mct_q   <= mct_d;
            eff_q   <= eff_d;
            ireg_q  <= ireg_d;
            ext_q   <= ext_d;
            pend_q  <= pend_d;
            start_q <= start_d;
            ill_q   <= ill_d;
        end
    end

    assign fetch_req     = state_q == S_LOAD;
    assign state         = state_q;
    assign tp            = tp_q;
    assign mct           = mct_q;
    assign eff_instr     = eff_q;
    assign op_start      = start_q;
    assign op_done       = last;
    assign extracode     = ext_q;
    assign index_pending = pend_q;
    assign illegal       = ill_q;
endmodule

// File: tb/tb_agc_seq_fsm.sv
// tb_agc_seq_fsm: randomized scoreboard bench for agc_seq_fsm against an instruction-level model.
module tb_agc_seq_fsm;
    localparam int TP  = 12;
    localparam int TPW = $clog2(TP);

    logic           clk = 0, rst_n = 0, instr_valid = 0;
    logic [14:0]    instr_in = 0, index_val = 0;
    logic           fetch_req, op_start, op_done, extracode, index_pending, illegal;
    logic [4:0]     state;
    logic [TPW-1:0] tp;
    logic [2:0]     mct;
    logic [14:0]    eff_instr;

    agc_seq_fsm dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_in(instr_in),
        .index_val(index_val), .fetch_req(fetch_req), .state(state), .tp(tp), .mct(mct),
        .eff_instr(eff_instr), .op_start(op_start), .op_done(op_done), .extracode(extracode),
        .index_pending(index_pending), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ill;
        logic [4:0]  st;
        logic [14:0] eff;
        int          cyc;
        bit          ext;
        bit          pend;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0, errors = 0;
    bit          mon_en = 0;
    bit          m_ext = 0, m_pend = 0;
    logic [14:0] m_ireg = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level reference: which instruction a word is, given the extracode mode.
    function automatic logic [4:0] decode(input logic [14:0] w, input bit ext);
        logic [2:0] op;
        logic [1:0] qc;
        op = w[14:12];
        qc = w[11:10];
        if (w == 15'd6) return 5'd12;
        if (ext) begin
            case (op)
                3'd1: return (qc == 0) ? 5'd11 : 5'd0;
                3'd5: return (qc == 0) ? 5'd3 : 5'd0;
                3'd6: return 5'd9;
                3'd7: return 5'd10;
                default: return 5'd0;
            endcase
        end
        case (op)
            3'd0: return 5'd1;
            3'd1: return 5'd2;
            3'd4: return 5'd5;
            3'd5: return (qc == 0) ? 5'd3 : (qc == 2) ? 5'd6 : (qc == 3) ? 5'd4 : 5'd0;
            3'd6: return 5'd7;
            3'd7: return 5'd8;
            default: return 5'd0;
        endcase
    endfunction

    function automatic int mcts(input logic [4:0] st);
        case (st)
            5'd1, 5'd3, 5'd12: return 1;
            5'd10: return 3;
            5'd11: return 6;
            default: return 2;
        endcase
    endfunction

    task automatic model_push(input logic [14:0] word, input logic [14:0] iv);
        exp_t e;
        e.eff  = word + (m_pend ? m_ireg : 15'd0);
        e.st   = decode(e.eff, m_ext);
        e.ill  = e.st == 0;
        e.cyc  = TP * mcts(e.st);
        m_pend = 0;
        if (e.ill) m_ext = 0;
        else if (e.st == 5'd3) begin
            m_ireg = iv;
            m_pend = 1;
        end else m_ext = (e.st == 5'd12);
        e.ext  = m_ext;
        e.pend = m_pend;
        sbq.push_back(e);
    endtask

    task automatic issue(input logic [14:0] word, input logic [14:0] iv, input int gap);
        int n = 0;
        while (!fetch_req && n < 200) begin
            instr_valid = 1'($urandom_range(0, 1));
            instr_in    = 15'($urandom);
            n++;
            @(negedge clk);
        end
        instr_valid = 0;
        chk("fetch_wait_timeout", {31'd0, fetch_req}, 1);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            chk("idle_fetch_req", {31'd0, fetch_req}, 1);
            chk("idle_state", {27'd0, state}, 0);
        end
        index_val   = iv;
        instr_valid = 1;
        instr_in    = word;
        model_push(word, iv);
        @(negedge clk);
        instr_valid = 0;
    endtask

    int   cnt = 0;
    bit   after = 0;
    exp_t done_rec;

    always @(negedge clk) begin
        if (mon_en) begin
            if (after) begin
                after = 0;
                chk("post_extracode", {31'd0, extracode}, {31'd0, done_rec.ext});
                chk("post_index_pending", {31'd0, index_pending}, {31'd0, done_rec.pend});
                chk("post_state_load", {27'd0, state}, 0);
            end
            if (op_start && op_done) chk("start_done_overlap", 1, 0);
            if (cnt > 0) cnt++;
            if (op_start) begin
                cnt = 1;
                chk("sb_nonempty_start", {31'd0, sbq.size() != 0}, 1);
                if (sbq.size() != 0) begin
                    chk("start_is_legal", {31'd0, sbq[0].ill}, 0);
                    chk("start_state", {27'd0, state}, {27'd0, sbq[0].st});
                    chk("start_eff", {17'd0, eff_instr}, {17'd0, sbq[0].eff});
                    chk("start_tp_mct", {25'd0, 4'(tp), mct}, 0);
                end
            end
            if (op_done) begin
                chk("sb_nonempty_done", {31'd0, sbq.size() != 0}, 1);
                if (sbq.size() != 0) begin
                    done_rec = sbq.pop_front();
                    chk("done_state", {27'd0, state}, {27'd0, done_rec.st});
                    chk("done_cycles", cnt, done_rec.cyc);
                    chk("done_eff", {17'd0, eff_instr}, {17'd0, done_rec.eff});
                    chk("done_mct", {29'd0, mct}, done_rec.cyc / TP - 1);
                    after = 1;
                end
                cnt = 0;
            end
            if (illegal) begin
                chk("sb_nonempty_ill", {31'd0, sbq.size() != 0}, 1);
                if (sbq.size() != 0) begin
                    done_rec = sbq.pop_front();
                    chk("ill_expected", {31'd0, done_rec.ill}, 1);
                    chk("ill_state", {27'd0, state}, 0);
                    chk("ill_eff", {17'd0, eff_instr}, {17'd0, done_rec.eff});
                    chk("ill_flags", {30'd0, extracode, index_pending}, 0);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [14:0] wd, iv;
        #12;
        chk("rst_state", {27'd0, state}, 0);
        chk("rst_tp_mct", {25'd0, 4'(tp), mct}, 0);
        chk("rst_eff", {17'd0, eff_instr}, 0);
        chk("rst_flags", {28'd0, op_start, illegal, extracode, index_pending}, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_fetch_req", {31'd0, fetch_req}, 1);
        // EXTEND then MP, interrupted by reset at mct=1 tp=5.
        instr_valid = 1;
        instr_in    = 15'h0006;
        @(negedge clk);
        instr_valid = 0;
        n = 0;
        while (!fetch_req && n < 50) begin n++; @(negedge clk); end
        chk("ext_then_load", {31'd0, fetch_req}, 1);
        chk("ext_extracode", {31'd0, extracode}, 1);
        instr_valid = 1;
        instr_in    = 15'h7000;
        @(negedge clk);
        instr_valid = 0;
        n = 0;
        while (!(state == 5'd10 && mct == 1 && tp == 5) && n < 100) begin n++; @(negedge clk); end
        chk("mp_reached", {27'd0, state}, 10);
        #2 rst_n = 0;
        #1;
        chk("async_rst_state", {27'd0, state}, 0);
        chk("async_rst_tp_mct", {25'd0, 4'(tp), mct}, 0);
        chk("async_rst_extracode", {31'd0, extracode}, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rel_fetch_req", {31'd0, fetch_req}, 1);
        chk("rel_state", {27'd0, state}, 0);
        mon_en = 1;
        issue(15'h4000, 15'h0000, 0);
        issue(15'h0006, 15'h0000, 0);
        issue(15'h7000, 15'h0000, 0);
        issue(15'h5000, 15'h1000, 0);
        issue(15'h5000, 15'h0000, 0);
        issue(15'h2000, 15'h0000, 0);
        issue(15'h0000, 15'h0000, 3);
        issue(15'h0006, 15'h0000, 0);
        issue(15'h5000, 15'h0000, 0);
        issue(15'h1000, 15'h0000, 0);
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 5))
                0: wd = 15'h0006;
                1: wd = {3'd5, 2'd0, 10'($urandom)};
                2: wd = {3'($urandom_range(5, 7)), 12'($urandom)};
                default: wd = 15'($urandom);
            endcase
            iv = ($urandom_range(0, 2) == 0) ? 15'($urandom) : 15'd0;
            issue(wd, iv, $urandom_range(0, 2));
        end
        n = 0;
        while ((sbq.size() != 0 || after) && n < 200) begin n++; @(negedge clk); end
        @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/agc_seq_fsm.md
Name: agc_seq_fsm

Overview:
Parametrised successor to the Apollo instruction-decode FSM. It fetches an instruction word over a valid/req handshake and applies INDEX addition and EXTEND extracode qualification. It decodes to an execution state, then sequences timepulses (TP) and memory cycle times (MCT) per instruction before returning to Load. It sits between the memory interface and the datapath control-pulse generator, which consumes state/tp/mct.

Parameters:
WORD_W, 15, instruction word width (>=15); opcode=instr[14:12], QC=instr[11:10]
TP_PER_MCT, 12, clock cycles (timepulses) per MCT (>=2)
TC_MCT, 1, MCTs for TC, INDEX, EXTEND
STD_MCT, 2, MCTs for CCS, XCH, CS, TS, AD, MASK, SU
MP_MCT, 3, MCTs for MP
DV_MCT, 6, MCTs for DV

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instr_in valid this cycle
instr_in  in  WORD_W  fetched instruction word
index_val  in  WORD_W  INDEX operand, sampled on the last TP of INDEX
fetch_req  out  1  high in Load while awaiting instr_valid
state  out  5  Load=0, Tc=1, Ccs=2, Index=3, Xch=4, Cs=5, Ts=6, Ad=7, Mask=8, Su=9, Mp=10, Dv=11, Extend=12
tp  out  $clog2(TP_PER_MCT)  timepulse within current MCT, 0..TP_PER_MCT-1
mct  out  3  MCT index within instruction
eff_instr  out  WORD_W  decoded (post-index) instruction, held through execution
op_start  out  1  1-cycle pulse on entry to an execution state
op_done  out  1  1-cycle pulse on final TP of final MCT
extracode  out  1  EXTEND pending/active
index_pending  out  1  next fetched word is indexed
illegal  out  1  1-cycle pulse on undecodable word

Behaviour:
- Reset (async, any time incl. mid-instruction): state=Load, tp=0, mct=0, eff_instr=0, extracode=0, index_pending=0, all pulses 0, fetch_req=1 after release.
- Load: fetch_req=1. If instr_valid=0, hold. On instr_valid=1: w = instr_in + (index_pending ? index_ireg : 0), mod 2^WORD_W. Register w into eff_instr, clear index_pending, decode w, go to target state with tp=0, mct=0, op_start=1 the next cycle. Load lasts >=1 cycle; back-to-back instr_valid is accepted only in Load.
- Decode, extracode=0: w==6 -> Extend; op0 -> Tc; op1 -> Ccs; op4 -> Cs; op5 QC0 -> Index; op5 QC2 -> Ts; op5 QC3 -> Xch; op6 -> Ad; op7 -> Mask.
- Decode, extracode=1: op1 QC0 -> Dv; op5 QC0 -> Index; op6 -> Su; op7 -> Mp.
- All other words: illegal=1 for 1 cycle, stay in Load, extracode cleared, index_pending cleared.
- Execution: tp increments every cycle. At tp=TP_PER_MCT-1, tp wraps to 0 and mct increments. On the final TP of the final MCT (count per class above): op_done=1, next state Load.
- Index completion: index_ireg<=index_val, index_pending<=1. extracode is preserved across INDEX.
- Extend completion: extracode<=1. Extend while extracode=1 keeps it at 1.
- Completion of any other execution state clears extracode.
- op_start and op_done never coincide. With TC_MCT=1 and TP_PER_MCT=2, an instruction occupies exactly 2 cycles plus 1 Load cycle.
- instr_valid outside Load is ignored, with no side effects.

Test Plan:
- Reset mid-Mp (mct=1,tp=5), deassert -> state=0, tp=0, mct=0, fetch_req=1, extracode=0 next cycle.
- instr_in=0x4000 (op4) in Load -> state=Cs, op_start; op_done at 2*12=24th exec cycle, then state=Load.
- instr_in=0x0006, then 0x7000 -> Extend (12 cycles, extracode=1), then Mp for 36 cycles; extracode=0 after op_done.
- instr_in=0x5000, index_val=0x1000, then instr_in=0x5000 -> Index, then w=0x6000 -> Ad; eff_instr=0x6000; index_pending cleared on fetch.
- instr_in=0x2000 with extracode=0 -> illegal pulse, state stays Load, no op_start; instr_valid held low in Load -> fetch_req stays 1, state 0.
- EXTEND, INDEX(index_val=0x0000), then 0x1000 -> Dv (extracode survives INDEX), 72 cycles, op_done.
